// File: rtl/mod_div_pkg.sv
// Shared definitions for the SM2 modular divider.
//   SM2_W : operand width in bits
//   SM2_P : SM2 prime field modulus
//   state_e : divider FSM states (IDLE, LOOP, DONE)
package mod_div_pkg;

    localparam int unsigned SM2_W = 256;

    localparam logic [SM2_W-1:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_half.sv
// Combinational modular halving: o_y = i_x / 2 mod P for odd P and i_x in [0,P).
//   i_x : W-bit field element
//   o_y : W-bit field element, i_x * 2^-1 mod P
module mod_half
    import mod_div_pkg::*;
#(
    parameter int unsigned     W = SM2_W,
    parameter logic [W-1:0]    P = SM2_P
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    // Odd x gets P added so the sum is even; the extra bit keeps the carry.
    logic [W:0] w_sum;
    logic       w_sum_lsb_unused;

    always_comb begin
        w_sum = {1'b0, i_x} + (i_x[0] ? {1'b0, P} : {(W+1){1'b0}});
    end

    assign o_y              = w_sum[W:1];
    assign w_sum_lsb_unused = w_sum[0];

endmodule

// File: rtl/mod_div.sv
// Modular divider: result = a * b^-1 mod P via the binary extended Euclid algorithm.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   start  : request strobe, sampled only in IDLE
//   a, b   : dividend and divisor (a < P, 0 < b < P)
//   busy   : high from the cycle after acceptance through the DONE cycle
//   done   : one-cycle pulse, result/err valid
//   result : quotient, held until the next completion
//   err    : set with done for illegal operands
module mod_div
    import mod_div_pkg::*;
#(
    parameter int unsigned     W = SM2_W,
    parameter logic [W-1:0]    P = SM2_P
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         err
);

    state_e       r_state, w_state_d;
    logic [W-1:0] r_u, w_u_d;
    logic [W-1:0] r_v, w_v_d;
    logic [W-1:0] r_x1, w_x1_d;
    logic [W-1:0] r_x2, w_x2_d;
    logic [W-1:0] r_result, w_result_d;
    logic         r_err, w_err_d;

    logic [W-1:0] w_x1_half;
    logic [W-1:0] w_x2_half;

    mod_half #(
        .W (W),
        .P (P)
    ) u_half_x1 (
        .i_x (r_x1),
        .o_y (w_x1_half)
    );

    mod_half #(
        .W (W),
        .P (P)
    ) u_half_x2 (
        .i_x (r_x2),
        .o_y (w_x2_half)
    );

    // One subtractor pair serves both u-v and v-u; operands swap on the compare.
    logic         w_u_ge_v;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_x_lhs;
    logic [W-1:0] w_x_rhs;
    logic [W:0]   w_x_sub;
    logic [W-1:0] w_x_diff;
    logic         w_illegal;

    always_comb begin
        w_u_ge_v = (r_u >= r_v);
        w_diff   = w_u_ge_v ? (r_u - r_v) : (r_v - r_u);
        w_x_lhs  = w_u_ge_v ? r_x1 : r_x2;
        w_x_rhs  = w_u_ge_v ? r_x2 : r_x1;
        w_x_sub  = {1'b0, w_x_lhs} - {1'b0, w_x_rhs};
        // A borrow means the difference wrapped; adding P brings it back into [0,P).
        w_x_diff = w_x_sub[W] ? (w_x_sub[W-1:0] + P) : w_x_sub[W-1:0];
        w_illegal = (b == '0) || (b >= P) || (a >= P);
    end

    always_comb begin
        w_state_d  = r_state;
        w_u_d      = r_u;
        w_v_d      = r_v;
        w_x1_d     = r_x1;
        w_x2_d     = r_x2;
        w_result_d = r_result;
        w_err_d    = r_err;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_illegal) begin
                        w_state_d  = DONE;
                        w_result_d = '0;
                        w_err_d    = 1'b1;
                    end else begin
                        w_state_d = LOOP;
                        w_u_d     = b;
                        w_v_d     = P;
                        w_x1_d    = a;
                        w_x2_d    = '0;
                    end
                end
            end
            LOOP: begin
                if ((r_u == W'(1)) || (r_v == W'(1))) begin
                    w_state_d  = DONE;
                    w_result_d = (r_u == W'(1)) ? r_x1 : r_x2;
                    w_err_d    = 1'b0;
                end else if (!r_u[0]) begin
                    w_u_d  = r_u >> 1;
                    w_x1_d = w_x1_half;
                end else if (!r_v[0]) begin
                    w_v_d  = r_v >> 1;
                    w_x2_d = w_x2_half;
                end else if (w_u_ge_v) begin
                    w_u_d  = w_diff;
                    w_x1_d = w_x_diff;
                end else begin
                    w_v_d  = w_diff;
                    w_x2_d = w_x_diff;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_u      <= '0;
            r_v      <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_u      <= w_u_d;
            r_v      <= w_v_d;
            r_x1     <= w_x1_d;
            r_x2     <= w_x2_d;
            r_result <= w_result_d;
            r_err    <= w_err_d;
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign err    = r_err;

endmodule

// File: tb/tb_mod_div.sv
module tb_mod_div;

    localparam int unsigned W = 256;
    localparam logic [W-1:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [W-1:0] HALF =
        256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_80000000_00000000;
    localparam logic [W-1:0] RT_A =
        256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    localparam logic [W-1:0] RT_B =
        256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
    localparam int MAX_CYC = 1100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;

    mod_div #(
        .W (W),
        .P (P)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Reference model: plain field arithmetic, inverse by Fermat's little theorem.
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        p = p % {{W{1'b0}}, P};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] powmod(input logic [W-1:0] base, input logic [W-1:0] e);
        logic [W-1:0] r;
        r = W'(1);
        for (int i = W - 1; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, base);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
        return mulmod(x, powmod(y, P - W'(2)));
    endfunction

    function automatic logic [W-1:0] rand_elem();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        if (r >= P) r = r - P;
        return r;
    endfunction

    // Issues one request from IDLE and waits (bounded) for done; returns at the done cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          output logic [W-1:0] res, output logic e,
                          output int cyc, output bit timeout);
        @(posedge clk); #1;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        timeout = 1'b1;
        res = '0;
        e = 1'b0;
        while (cyc <= MAX_CYC) begin
            if (done === 1'b1) begin
                res = result;
                e = err;
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_done: got %b expected 0", done);
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_err: got %b expected 0", err);
        end
        tests_run++;
        if (result !== '0) begin
            tests_failed++; $display("FAIL reset_result: got %h expected 0", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] ta [4];
        logic [W-1:0] tbv [4];
        logic [W-1:0] texp [4];
        logic [W-1:0] res;
        logic e;
        int cyc;
        bit to;
        ta[0] = W'(1); tbv[0] = W'(1); texp[0] = W'(1);
        ta[1] = W'(6); tbv[1] = W'(3); texp[1] = W'(2);
        ta[2] = W'(1); tbv[2] = W'(2); texp[2] = HALF;
        ta[3] = W'(0); tbv[3] = W'(5); texp[3] = W'(0);
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tbv[i], res, e, cyc, to);
            tests_run++;
            if (to) begin
                tests_failed++; $display("FAIL basic_timeout[%0d]: got no done expected done", i);
            end
            tests_run++;
            if (res !== texp[i]) begin
                tests_failed++; $display("FAIL basic_result[%0d]: got %h expected %h", i, res, texp[i]);
            end
            tests_run++;
            if (e !== 1'b0) begin
                tests_failed++; $display("FAIL basic_err[%0d]: got %b expected 0", i, e);
            end
        end
    endtask

    task automatic test_errors();
        logic [W-1:0] ta [4];
        logic [W-1:0] tbv [4];
        logic [W-1:0] res;
        logic e;
        int cyc;
        bit to;
        ta[0] = W'(5); tbv[0] = W'(0);
        ta[1] = W'(5); tbv[1] = P;
        ta[2] = P;     tbv[2] = W'(1);
        ta[3] = '1;    tbv[3] = W'(7);
        for (int i = 0; i < 4; i++) begin
            // Leave a nonzero result behind so the cleared result is observable.
            run_op(W'(6), W'(3), res, e, cyc, to);
            run_op(ta[i], tbv[i], res, e, cyc, to);
            tests_run++;
            if (to || cyc != 1) begin
                tests_failed++;
                $display("FAIL err_latency[%0d]: got %0d cycles expected 1", i, cyc);
            end
            tests_run++;
            if (e !== 1'b1) begin
                tests_failed++; $display("FAIL err_flag[%0d]: got %b expected 1", i, e);
            end
            tests_run++;
            if (res !== '0) begin
                tests_failed++; $display("FAIL err_result[%0d]: got %h expected 0", i, res);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [W-1:0] c;
        logic [W-1:0] res;
        logic e;
        int cyc;
        bit to;
        c = mulmod(RT_A, RT_B);
        run_op(c, RT_B, res, e, cyc, to);
        tests_run++;
        if (to || res !== RT_A) begin
            tests_failed++; $display("FAIL roundtrip: got %h expected %h", res, RT_A);
        end
        tests_run++;
        if (e !== 1'b0) begin
            tests_failed++; $display("FAIL roundtrip_err: got %b expected 0", e);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] exp_r;
        logic [W-1:0] res;
        logic e;
        int cyc;
        bit to;
        for (int i = 0; i < 8; i++) begin
            ra = (i == 0) ? '0 : rand_elem();
            rb = rand_elem();
            while (rb == '0) rb = rand_elem();
            exp_r = ref_div(ra, rb);
            run_op(ra, rb, res, e, cyc, to);
            tests_run++;
            if (to) begin
                tests_failed++; $display("FAIL rand_timeout[%0d]: got %0d cycles expected <= %0d", i, cyc, MAX_CYC);
            end
            tests_run++;
            if (res !== exp_r || e !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_result[%0d]: got %h err %b expected %h err 0", i, res, e, exp_r);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cnt0;
        int cyc;
        bit seen;
        @(posedge clk); #1;
        @(negedge clk);
        a = mulmod(RT_A, RT_B);
        b = RT_B;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt0 = done_cnt;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++; $display("FAIL busy_after_accept: got busy %b done %b expected 1 0", busy, done);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        a = W'(6);
        b = W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        cyc = 0;
        while (cyc < MAX_CYC) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            a = rand_elem();
            b = rand_elem();
        end
        tests_run++;
        if (!seen || result !== RT_A || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignore_result: got %h done_seen %b expected %h", result, seen, RT_A);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL busy_in_done: got %b expected 1", busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL busy_after_done: got busy %b done %b expected 0 0", busy, done);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt - cnt0 != 1) begin
            tests_failed++; $display("FAIL busy_done_pulses: got %0d expected 1", done_cnt - cnt0);
        end
    endtask

    task automatic test_done_start();
        logic [W-1:0] res;
        logic e;
        int cyc;
        bit to;
        bit seen;
        run_op(W'(1), W'(1), res, e, cyc, to);
        tests_run++;
        if (to || res !== W'(1)) begin
            tests_failed++; $display("FAIL done_start_first: got %h expected 1", res);
        end
        // Still in the DONE cycle: this start must be ignored.
        a = W'(6);
        b = W'(3);
        start = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL done_start_ignored: got busy %b expected 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL done_start_next: got busy %b expected 1", busy);
        end
        seen = 1'b0;
        for (int i = 0; i < MAX_CYC; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (!seen || result !== W'(2)) begin
            tests_failed++; $display("FAIL done_start_result: got %h done_seen %b expected 2", result, seen);
        end
    endtask

    task automatic test_reset_midloop();
        int cnt0;
        logic [W-1:0] res;
        logic e;
        int cyc;
        bit to;
        @(posedge clk); #1;
        @(negedge clk);
        a = mulmod(RT_A, RT_B);
        b = RT_B;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt0 = done_cnt;
        repeat (49) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_state: got busy %b done %b expected 0 0", busy, done);
        end
        tests_run++;
        if (result !== '0 || err !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_outputs: got %h err %b expected 0 0", result, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt != cnt0) begin
            tests_failed++; $display("FAIL midreset_no_done: got %0d pulses expected 0", done_cnt - cnt0);
        end
        run_op(W'(6), W'(3), res, e, cyc, to);
        tests_run++;
        if (to || res !== W'(2) || e !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_restart: got %h err %b expected 2 err 0", res, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_roundtrip();
        test_random();
        test_busy_ignore();
        test_done_start();
        test_reset_midloop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
